// File: rtl/miner_feeder_pkg.sv
// Shared types and helpers for the Miner job feeder: FSM state encoding, datapath widths,
// and the byte-count to word-count conversion.
package miner_feeder_pkg;

    localparam int NONCE_W = 192;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [31:0] ceil_words(input logic [31:0] nbytes);
        return (nbytes + 32'd3) >> 2;
    endfunction

endpackage

// File: rtl/msg_word_buf.sv
// Header word buffer: MSG_WORDS x 32-bit flop array with synchronous write and
// asynchronous read. Contents are intentionally not reset.
module msg_word_buf
    import miner_feeder_pkg::*;
#(
    parameter int  MSG_WORDS = 72,
    localparam int AW        = $clog2(MSG_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [MSG_WORDS];

    // Addresses past the buffer depth are dropped rather than aliased.
    always_ff @(posedge clk_i) begin
        if (we_i && ({1'b0, waddr_i} < (AW+1)'(MSG_WORDS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/miner_job_feeder.sv
// Job-source end of the Miner header interface: buffers one header, launches hashes and sweeps
// the nonce until the Miner reports a hit. Define MINER_FEEDER_TIMEOUT_EN for the watchdog relaunch.
module miner_job_feeder
    import miner_feeder_pkg::*;
#(
    parameter int  MSG_WORDS   = 72,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int AW          = $clog2(MSG_WORDS)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               WrEn_I,
    input  logic [AW-1:0]      WrAddr_I,
    input  logic [WORD_W-1:0]  WrData_I,
    input  logic [31:0]        ByteNum_I,
    input  logic [NONCE_W-1:0] NonceBase_I,
    input  logic               Start_I,
    input  logic               Stop_I,
    output logic               Update_O,
    output logic [WORD_W-1:0]  Msg_O,
    input  logic               Next_I,
    output logic [NONCE_W-1:0] Nonce_O,
    input  logic               Rdy_I,
    input  logic               Vld_I,
    output logic               Busy_O,
    output logic               Found_O,
    output logic [NONCE_W-1:0] FoundNonce_O,
    output logic [31:0]        HashCnt_O,
    output logic               CfgErr_O,
    output logic               OverRead_O,
    output logic               Timeout_O
);

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      last_q, last_d;
    logic               past_q, past_d;
    logic [1:0]         rem_q, rem_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] fnonce_q, fnonce_d;
    logic [31:0]        hcnt_q, hcnt_d;
    logic               cfgerr_q, cfgerr_d;
    logic               ovr_q, ovr_d;
    logic               rdy_q;

    logic               rdy_rise;
    logic               start_ok;
    logic               active;
    logic               wd_expire;
    logic [WORD_W-1:0]  buf_word;
    logic [WORD_W-1:0]  word_masked;

    assign rdy_rise = Rdy_I & ~rdy_q;
    assign start_ok = (ByteNum_I != 32'd0) && (ByteNum_I <= 32'(MSG_WORDS * 4));
    assign active   = (state_q == LAUNCH) || (state_q == RUN);

    msg_word_buf #(.MSG_WORDS(MSG_WORDS)) u_buf (
        .clk_i   (Clk),
        .we_i    (WrEn_I && (state_q == IDLE)),
        .waddr_i (WrAddr_I),
        .wdata_i (WrData_I),
        .raddr_i (ptr_q),
        .rdata_o (buf_word)
    );

`ifdef MINER_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;
    logic            start_go;

    assign start_go  = ((state_q == IDLE) || (state_q == DONE)) && Start_I && !Stop_I && start_ok;
    assign wd_expire = (state_q == RUN) && !rdy_rise && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d  = wd_q;
        tmo_d = tmo_q;
        if ((state_q != RUN) || rdy_rise || wd_expire) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        if (start_go) begin
            tmo_d = 1'b0;
        end else if (wd_expire) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign Timeout_O = tmo_q;
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign Timeout_O          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        past_d   = past_q;
        rem_d    = rem_q;
        nonce_d  = nonce_q;
        fnonce_d = fnonce_q;
        hcnt_d   = hcnt_q;
        cfgerr_d = cfgerr_q;
        ovr_d    = ovr_q;

        // Consuming the last word empties Msg_O; only a request after that is an over-read.
        if (active && Next_I) begin
            if (past_q) begin
                ovr_d = 1'b1;
            end else if (ptr_q == last_q) begin
                past_d = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (Start_I && !Stop_I) begin
                    if (start_ok) begin
                        state_d  = LAUNCH;
                        ptr_d    = '0;
                        past_d   = 1'b0;
                        last_d   = AW'(ceil_words(ByteNum_I) - 32'd1);
                        rem_d    = ByteNum_I[1:0];
                        nonce_d  = NonceBase_I;
                        hcnt_d   = '0;
                        cfgerr_d = 1'b0;
                        ovr_d    = 1'b0;
                    end else begin
                        cfgerr_d = 1'b1;
                    end
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (rdy_rise) begin
                    hcnt_d = (hcnt_q == 32'hFFFF_FFFF) ? hcnt_q : hcnt_q + 32'd1;
                    if (Vld_I) begin
                        state_d  = DONE;
                        fnonce_d = nonce_q;
                    end else begin
                        state_d = LAUNCH;
                        nonce_d = nonce_q + NONCE_W'(1);
                        ptr_d   = '0;
                        past_d  = 1'b0;
                    end
                end else if (wd_expire) begin
                    state_d = LAUNCH;
                    ptr_d   = '0;
                    past_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A hit reported in the same cycle as Stop is kept.
        if (Stop_I && !((state_q == RUN) && rdy_rise && Vld_I)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        word_masked = buf_word;
        if ((ptr_q == last_q) && (rem_q != 2'd0)) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) >= rem_q) begin
                    word_masked[8*k +: 8] = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            last_q   <= '0;
            past_q   <= 1'b0;
            rem_q    <= '0;
            nonce_q  <= '0;
            fnonce_q <= '0;
            hcnt_q   <= '0;
            cfgerr_q <= 1'b0;
            ovr_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            past_q   <= past_d;
            rem_q    <= rem_d;
            nonce_q  <= nonce_d;
            fnonce_q <= fnonce_d;
            hcnt_q   <= hcnt_d;
            cfgerr_q <= cfgerr_d;
            ovr_q    <= ovr_d;
            rdy_q    <= Rdy_I;
        end
    end

    assign Update_O     = (state_q == LAUNCH);
    assign Busy_O       = active;
    assign Found_O      = (state_q == DONE);
    assign Msg_O        = (active && !past_q) ? word_masked : '0;
    assign Nonce_O      = nonce_q;
    assign FoundNonce_O = fnonce_q;
    assign HashCnt_O    = hcnt_q;
    assign CfgErr_O     = cfgerr_q;
    assign OverRead_O   = ovr_q;

endmodule

// File: tb/tb_miner_job_feeder.sv
// Testbench for miner_job_feeder: table-driven job vectors, hand-written corner sequences and
// randomized jobs checked against a byte-level header model and plain nonce arithmetic.
module tb_miner_job_feeder;

    localparam int MW     = 72;
    localparam int TO_CYC = 16;
    localparam int AW     = $clog2(MW);

    logic           Clk, Rst_n;
    logic           WrEn_I, Start_I, Stop_I, Next_I, Rdy_I, Vld_I;
    logic [AW-1:0]  WrAddr_I;
    logic [31:0]    WrData_I, ByteNum_I;
    logic [191:0]   NonceBase_I;
    logic           Update_O, Busy_O, Found_O, CfgErr_O, OverRead_O, Timeout_O;
    logic [31:0]    Msg_O, HashCnt_O;
    logic [191:0]   Nonce_O, FoundNonce_O;

    int n_pass  = 0;
    int n_total = 0;
    int upd_cnt = 0;

    logic [7:0] mbyte [MW*4];

    typedef struct {
        logic [31:0]  nb;
        logic [191:0] base;
        int           nfail;
        logic         cfgerr;
        logic [191:0] fnonce;
    } vec_t;

    vec_t vecs [8];

    miner_job_feeder #(.MSG_WORDS(MW), .TIMEOUT_CYC(TO_CYC)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .WrEn_I       (WrEn_I),
        .WrAddr_I     (WrAddr_I),
        .WrData_I     (WrData_I),
        .ByteNum_I    (ByteNum_I),
        .NonceBase_I  (NonceBase_I),
        .Start_I      (Start_I),
        .Stop_I       (Stop_I),
        .Update_O     (Update_O),
        .Msg_O        (Msg_O),
        .Next_I       (Next_I),
        .Nonce_O      (Nonce_O),
        .Rdy_I        (Rdy_I),
        .Vld_I        (Vld_I),
        .Busy_O       (Busy_O),
        .Found_O      (Found_O),
        .FoundNonce_O (FoundNonce_O),
        .HashCnt_O    (HashCnt_O),
        .CfgErr_O     (CfgErr_O),
        .OverRead_O   (OverRead_O),
        .Timeout_O    (Timeout_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Update_O) upd_cnt <= upd_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Header word idx as the Miner should see it: bytes at or past the byte count read as zero.
    function automatic logic [31:0] exp_word(input int idx, input logic [31:0] nb);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (idx * 4 + k < int'(nb)) w[8*k +: 8] = mbyte[idx*4 + k];
        end
        return w;
    endfunction

    task automatic load_msg(input bit rnd);
        logic [31:0] w;
        for (int a = 0; a < MW; a++) begin
            for (int k = 0; k < 4; k++) begin
                mbyte[a*4 + k] = rnd ? 8'($urandom) : 8'(a * 4 + k + 8'h18);
                w[8*k +: 8]    = mbyte[a*4 + k];
            end
            WrEn_I = 1'b1; WrAddr_I = AW'(a); WrData_I = w;
            cyc();
        end
        WrEn_I = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] nb, input logic [191:0] base);
        ByteNum_I = nb; NonceBase_I = base; Start_I = 1'b1;
        cyc();
        Start_I = 1'b0;
    endtask

    task automatic stop_job();
        Stop_I = 1'b1;
        cyc();
        Stop_I = 1'b0;
        chk("stop_idle", {Busy_O, Found_O, Update_O, Msg_O}, 0);
    endtask

    task automatic wait_update();
        for (int i = 0; i < 50 && !Update_O; i++) cyc();
        chk("update_seen", Update_O, 1);
    endtask

    // Miner model: each hash reads some words, then reports Rdy; the last hash reports Vld.
    task automatic run_job(input logic [31:0] nb, input logic [191:0] base, input int nfail,
                           input logic [191:0] exp_fnonce, input bit full_read);
        int nw, c, nn, u0;
        bit ovr;
        nw  = (int'(nb) + 3) / 4;
        ovr = 1'b0;
        u0  = upd_cnt;
        start_job(nb, base);
        chk("cfgerr_clear", CfgErr_O, 0);
        for (int h = 0; h <= nfail; h++) begin
            wait_update();
            chk("nonce", Nonce_O, base + 192'(h));
            c = 0;
            chk("msg_launch", Msg_O, exp_word(0, nb));
            nn = (h == 0 && full_read) ? nw + 1 : int'($urandom_range(0, nw + 1));
            for (int i = 0; i < nn; i++) begin
                Next_I = 1'b1;
                cyc();
                if (c >= nw) ovr = 1'b1;
                else c++;
                chk("msg_next", Msg_O, exp_word(c, nb));
                chk("overread", OverRead_O, ovr);
            end
            Next_I = 1'b0;
            cyc();
            Rdy_I = 1'b1; Vld_I = (h == nfail);
            cyc();
            Rdy_I = 1'b0; Vld_I = 1'b0;
        end
        chk("found", {Found_O, Busy_O}, 2'b10);
        chk("found_nonce", FoundNonce_O, exp_fnonce);
        chk("hash_cnt", HashCnt_O, 32'(nfail + 1));
        chk("msg_done", Msg_O, 0);
        cyc();
        chk("update_count", upd_cnt - u0, nfail + 1);
    endtask

    initial begin
        int u0;
        logic [191:0] ones;
        logic [191:0] b2;
        logic [31:0]  nb;
        logic [191:0] base;
        int           nf;

        ones = {192{1'b1}};
        b2   = 192'h0000_0000_0000_0000_0000_0000_0000_0000_00ff_ffff_ffff_fffe;
        vecs[0] = '{32'd288,        192'h1234_5678_9abc, 0, 1'b0, 192'h1234_5678_9abc};
        vecs[1] = '{32'd64,         b2,                  3, 1'b0,
                    192'h0000_0000_0000_0000_0000_0000_0000_0000_0100_0000_0000_0001};
        vecs[2] = '{32'd8,          ones,                1, 1'b0, 192'd0};
        vecs[3] = '{32'd10,         192'd77,             0, 1'b0, 192'd77};
        vecs[4] = '{32'd0,          192'd1,              0, 1'b1, 192'd0};
        vecs[5] = '{32'd289,        192'd2,              0, 1'b1, 192'd0};
        vecs[6] = '{32'hFFFF_FFFF,  192'd3,              0, 1'b1, 192'd0};
        vecs[7] = '{32'd1,          192'd5,              2, 1'b0, 192'd7};

        Rst_n = 1'b0; WrEn_I = 1'b0; WrAddr_I = '0; WrData_I = '0; ByteNum_I = '0;
        NonceBase_I = '0; Start_I = 1'b0; Stop_I = 1'b0; Next_I = 1'b0; Rdy_I = 1'b0; Vld_I = 1'b0;
        repeat (2) cyc();
        chk("reset_outs", {Update_O, Busy_O, Found_O, CfgErr_O, OverRead_O, Timeout_O, Msg_O, HashCnt_O}, 0);
        chk("reset_nonces", {Nonce_O, FoundNonce_O}, 0);
        Rst_n = 1'b1;
        cyc();
        chk("idle_after_reset", {Busy_O, Found_O, Update_O}, 0);

        load_msg(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].cfgerr) begin
                u0 = upd_cnt;
                start_job(vecs[i].nb, vecs[i].base);
                chk("cfgerr_set", CfgErr_O, 1);
                chk("reject_idle", {Busy_O, Found_O}, 0);
                cyc();
                chk("reject_no_update", upd_cnt - u0, 0);
            end else begin
                run_job(vecs[i].nb, vecs[i].base, vecs[i].nfail, vecs[i].fnonce, 1'b1);
                stop_job();
            end
        end

        // Stop coinciding with a hit keeps the hit; Start from DONE opens a fresh job.
        start_job(32'd16, 192'd4242);
        wait_update();
        cyc();
        Rdy_I = 1'b1; Vld_I = 1'b1; Stop_I = 1'b1;
        cyc();
        Rdy_I = 1'b0; Vld_I = 1'b0; Stop_I = 1'b0;
        chk("stop_vld_done", {Found_O, Busy_O}, 2'b10);
        chk("stop_vld_fnonce", FoundNonce_O, 192'd4242);
        start_job(32'd16, 192'd9);
        chk("restart_from_done", {Busy_O, Found_O, Update_O}, 3'b101);
        chk("restart_hcnt", HashCnt_O, 0);
        cyc();
        Rdy_I = 1'b1; Vld_I = 1'b0; Stop_I = 1'b1;
        cyc();
        Rdy_I = 1'b0; Stop_I = 1'b0;
        chk("stop_rdy_idle", {Busy_O, Found_O, Update_O}, 0);

        // Host writes during a job must not reach the buffer.
        start_job(32'd40, 192'd1000);
        wait_update();
        cyc();
        WrEn_I = 1'b1; WrAddr_I = '0; WrData_I = ~exp_word(0, 32'd40);
        cyc();
        WrEn_I = 1'b0;
        Rdy_I = 1'b1;
        cyc();
        Rdy_I = 1'b0;
        wait_update();
        chk("write_ignored", Msg_O, exp_word(0, 32'd40));
        chk("relaunch_nonce", Nonce_O, 192'd1001);
        stop_job();

        // Asynchronous reset in the middle of a hash.
        start_job(32'd40, 192'd55);
        wait_update();
        Next_I = 1'b1;
        repeat (2) cyc();
        Next_I = 1'b0;
        u0 = upd_cnt;
        #1 Rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {Update_O, Busy_O, Found_O, CfgErr_O, OverRead_O, Timeout_O, Msg_O, HashCnt_O}, 0);
        chk("rst_mid_nonce", Nonce_O, 0);
        repeat (2) cyc();
        Rst_n = 1'b1;
        repeat (2) cyc();
        chk("rst_no_update", upd_cnt - u0, 0);
        chk("rst_idle", {Busy_O, Update_O}, 0);

        // Watchdog behaviour with no Rdy from the Miner.
        start_job(32'd16, 192'd900);
        wait_update();
        cyc();
        u0 = upd_cnt;
`ifdef MINER_FEEDER_TIMEOUT_EN
        for (int i = 0; i < TO_CYC + 8 && !Update_O; i++) cyc();
        chk("to_relaunch", Update_O, 1);
        chk("to_flag", Timeout_O, 1);
        chk("to_nonce", Nonce_O, 192'd900);
        chk("to_hcnt", HashCnt_O, 0);
`else
        repeat (TO_CYC * 3) cyc();
        chk("no_to_state", {Busy_O, Update_O, Timeout_O}, 3'b100);
        chk("no_to_updates", upd_cnt - u0, 0);
`endif
        stop_job();

        // Randomized jobs against the header/nonce model.
        for (int it = 0; it < 25; it++) begin
            load_msg(1'b1);
            nb   = (it % 5 == 0) ? 32'd288 : $urandom_range(1, 288);
            base = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (it % 7 == 3) base = ones - 192'($urandom_range(0, 2));
            nf   = int'($urandom_range(0, 3));
            run_job(nb, base, nf, base + 192'(nf), (it % 3 == 0));
            stop_job();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
